// File: rtl/fifo_reader_pkg.sv
// Shared types and defaults for the filter-path FIFO read controller.
// Holds the sample width / frame length defaults and the FSM state enum.
package fifo_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int FRAME_LEN_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus sample stream bundle between reader and its neighbours.
// master: the reader (drives fifo_rden, smp_*); slave: FIFO + consumer side.
interface fifo_reader_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              fifo_rden;
  logic [DATA_W-1:0] fifo_rddata;
  logic              fifo_empty;
  logic [DATA_W-1:0] smp_data;
  logic              smp_valid;
  logic              smp_ready;
  logic              smp_last;

  modport master (
    output fifo_rden,
    input  fifo_rddata,
    input  fifo_empty,
    output smp_data,
    output smp_valid,
    input  smp_ready,
    output smp_last
  );

  modport slave (
    input  fifo_rden,
    output fifo_rddata,
    output fifo_empty,
    input  smp_data,
    input  smp_valid,
    output smp_ready,
    input  smp_last
  );

endinterface

// File: rtl/fifo_reader_skid.sv
// fifo_rd_skid: 2-entry ring buffer absorbing the FIFO read latency.
// Ports: clk, rst_n (sync), wr_en/wr_data (tail write), pop, head, occ.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        occ
);

  logic [1:0][DATA_W-1:0] mem_q, mem_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic [1:0]             occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    // write+pop together leaves occupancy unchanged
    unique case (1'b1)
      wr_en & ~pop: occ_d = occ_q + 2'd1;
      pop & ~wr_en: occ_d = occ_q - 2'd1;
      default:      occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign occ  = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: pops a 1-cycle-latency FIFO into a framed valid/ready stream.
// Ports: fifo_clk, rst (sync, active-low), enable, busy, bus (master side),
// underrun_cnt (only when FIFO_RDR_UNDERRUN_EN is defined).
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
`ifdef FIFO_RDR_UNDERRUN_EN
  , parameter int CNT_W   = 16
`endif
) (
  input  logic             fifo_clk,
  input  logic             rst,
  input  logic             enable,
  output logic             busy,
`ifdef FIFO_RDR_UNDERRUN_EN
  output logic [CNT_W-1:0] underrun_cnt,
`endif
  fifo_reader_if.master    bus
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  state_e            state_q, state_d;
  logic              inflight_q, inflight_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        occ;
  logic [DATA_W-1:0] head;
  logic              valid;
  logic              pop;
  logic              rden;
  logic [2:0]        fill;

  fifo_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (fifo_clk),
    .rst_n   (rst),
    .wr_en   (inflight_q),
    .wr_data (bus.fifo_rddata),
    .pop     (pop),
    .head    (head),
    .occ     (occ)
  );

  assign valid = (occ != 2'd0);
  assign pop   = valid & bus.smp_ready;

  // entries that will be held next cycle if no read is issued now
  assign fill = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

  assign rden = rst & (state_q == S_RUN) & enable
              & ~bus.fifo_empty & (fill < 3'd2);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        if (!enable) begin
          state_d = (valid || inflight_q) ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (enable) begin
          state_d = S_RUN;
        end else if (!valid && !inflight_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inflight_d = rden;
    idx_d      = idx_q;
    if (state_d == S_IDLE && state_q != S_IDLE) begin
      idx_d = '0;
    end else if (pop) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge fifo_clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      inflight_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      idx_q      <= idx_d;
    end
  end

`ifdef FIFO_RDR_UNDERRUN_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // consumer starved while nothing is buffered, pending or available
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_RUN && bus.smp_ready && !valid
        && !inflight_q && bus.fifo_empty && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge fifo_clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign underrun_cnt = cnt_q;
`endif

  assign bus.fifo_rden = rden;
  assign bus.smp_valid = valid;
  assign bus.smp_data  = head;
  assign bus.smp_last  = valid & (idx_q == IDX_LAST);
  assign busy          = (state_q != S_IDLE);

endmodule
